// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: mem-op codes, FSM states and
// byte-lane helpers used by both the control path and the load aligner.
package lsu_pkg;

    // read_write codes coming from the decode control unit
    localparam logic [3:0] MEM_OP_NONE = 4'b0000;
    localparam logic [3:0] MEM_OP_LB   = 4'b1000;
    localparam logic [3:0] MEM_OP_LH   = 4'b1001;
    localparam logic [3:0] MEM_OP_LW   = 4'b1010;
    localparam logic [3:0] MEM_OP_SB   = 4'b1011;
    localparam logic [3:0] MEM_OP_LBU  = 4'b1100;
    localparam logic [3:0] MEM_OP_LHU  = 4'b1101;
    localparam logic [3:0] MEM_OP_SH   = 4'b1110;
    localparam logic [3:0] MEM_OP_SW   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp
    } lsu_state_e;

    function automatic logic lsu_is_mem_op(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU,
            MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    // Byte enables; half strobes use only offs[1] so a stray offs[0] is ignored
    function automatic logic [3:0] lsu_wstrb(input logic [3:0] op, input logic [1:0] offs);
        case (op)
            MEM_OP_SB: return 4'b0001 << offs;
            MEM_OP_SH: return 4'b0011 << {offs[1], 1'b0};
            MEM_OP_SW: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Replicate the store operand across every lane so the strobe picks the lane
    function automatic logic [31:0] lsu_wdata(input logic [3:0] op, input logic [31:0] data);
        case (op)
            MEM_OP_SB: return {4{data[7:0]}};
            MEM_OP_SH: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] offs);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half_op && offs[0]) || (word_op && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: picks the byte/half addressed by the low address bits
// out of the read word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [3:0]  mem_op_i,
    input  logic [1:0]  byte_offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by the op code
    always_comb begin
        byte_sel = rdata_i[8*byte_offset_i +: 8];
        half_sel = byte_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = rdata_i;
        unique case (mem_op_i)
            MEM_OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LBU: data_o = {24'h0, byte_sel};
            MEM_OP_LHU: data_o = {16'h0, half_sel};
            default:    data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid data-memory transaction per
// accepted op, stalling the pipeline until the access completes or times out.
// Optional feature macro: MISALIGN_TRAP_EN (reject misaligned half/word accesses).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [3:0]      mem_op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            stall_o,
    output logic            load_valid_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            bus_err_o,
    output logic            misaligned_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q;
    logic [3:0]  op_q;
    logic [1:0]  offs_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        load_valid_q;
    logic [31:0] load_data_q;
    logic        bus_err_q;

    logic        op_is_mem;
    logic        accept;
    logic        trap;
    logic        rsp_done;
    logic        timeout_hit;
    logic [31:0] aligned_data;

    assign op_is_mem   = lsu_is_mem_op(mem_op_i);
    assign op_ready_o  = (state_q == StIdle);
    assign accept      = op_valid_i & op_ready_o & op_is_mem;
    assign stall_o     = (state_q != StIdle) | (op_valid_i & op_is_mem);
    assign timeout_hit = (cnt_q == TimeoutLast);
    // A combined gnt+rvalid in REQ finishes the access without visiting WAIT_RSP
    assign rsp_done    = dmem_rvalid_i &
                         ((state_q == StWaitRsp) | ((state_q == StReq) & dmem_gnt_i));

`ifdef MISALIGN_TRAP_EN
    logic misaligned_q;
    assign trap         = lsu_misaligned(mem_op_i, addr_i[1:0]);
    assign misaligned_o = misaligned_q;
`else
    assign trap         = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_wstrb_o = wstrb_q;
    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
    assign bus_err_o    = bus_err_q;

    lsu_load_align u_load_align (
        .mem_op_i      (op_q),
        .byte_offset_i (offs_q),
        .rdata_i       (dmem_rdata_i),
        .data_o        (aligned_data)
    );

    // Transaction FSM with all bus and result outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            op_q         <= MEM_OP_NONE;
            offs_q       <= 2'b00;
            cnt_q        <= 8'h00;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            bus_err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= accept & trap;
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept && !trap) begin
                        op_q    <= mem_op_i;
                        offs_q  <= addr_i[1:0];
                        cnt_q   <= 8'h00;
                        req_q   <= 1'b1;
                        we_q    <= lsu_is_store(mem_op_i);
                        addr_q  <= {addr_i[31:2], 2'b00};
                        wdata_q <= lsu_wdata(mem_op_i, store_data_i);
                        wstrb_q <= lsu_wstrb(mem_op_i, addr_i[1:0]);
                        state_q <= StReq;
                    end
                end
                StReq, StWaitRsp: begin
                    if (rsp_done) begin
                        req_q   <= 1'b0;
                        cnt_q   <= 8'h00;
                        state_q <= StIdle;
                        if (!we_q) begin
                            load_valid_q <= 1'b1;
                            load_data_q  <= aligned_data;
                        end
                    end else if ((state_q == StReq) && dmem_gnt_i) begin
                        req_q   <= 1'b0;
                        cnt_q   <= 8'h00;
                        state_q <= StWaitRsp;
                    end else if (timeout_hit) begin
                        req_q     <= 1'b0;
                        cnt_q     <= 8'h00;
                        bus_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand sequences for bus stalls, timeout and mid-transaction reset.
module tb_load_store_unit;

    localparam logic [3:0] LB  = 4'b1000;
    localparam logic [3:0] LH  = 4'b1001;
    localparam logic [3:0] LW  = 4'b1010;
    localparam logic [3:0] SB  = 4'b1011;
    localparam logic [3:0] LBU = 4'b1100;
    localparam logic [3:0] LHU = 4'b1101;
    localparam logic [3:0] SH  = 4'b1110;
    localparam logic [3:0] SW  = 4'b1111;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_we;
        logic [31:0] exp_ldata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        bus_err;
    logic        misaligned;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_valid_i    (op_valid),
        .op_ready_o    (op_ready),
        .mem_op_i      (mem_op),
        .addr_i        (addr),
        .store_data_i  (sdata),
        .stall_o       (stall),
        .load_valid_o  (load_valid),
        .load_data_o   (load_data),
        .bus_err_o     (bus_err),
        .misaligned_o  (misaligned),
        .dmem_req_o    (req),
        .dmem_we_o     (we),
        .dmem_addr_o   (maddr),
        .dmem_wdata_o  (wdata),
        .dmem_wstrb_o  (wstrb),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One op: accept in c0, gnt after gnt_wait extra REQ cycles,
    // rvalid rsp_wait cycles after gnt (0 = same cycle as gnt)
    task automatic run_op(input vec_t v, input int gnt_wait, input int rsp_wait);
        op_valid = 1'b1;
        mem_op   = v.op;
        addr     = v.addr;
        sdata    = v.sdata;
        #1;
        chk("c0_stall", 32'(stall), 32'd1);
        chk("c0_ready", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        mem_op   = 4'h0;
        addr     = 32'h0;
        sdata    = 32'h0;
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i > 0) step();
            chk("req_high", 32'(req), 32'd1);
            chk("req_addr", maddr, v.exp_addr);
            chk("req_wstrb", 32'(wstrb), 32'(v.exp_wstrb));
            chk("req_we", 32'(we), 32'(v.exp_we));
            if (v.exp_we) chk("req_wdata", wdata, v.exp_wdata);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_ready", 32'(op_ready), 32'd0);
        end
        gnt = 1'b1;
        if (rsp_wait == 0) begin
            rvalid = 1'b1;
            rdata  = v.rdata;
        end
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        if (rsp_wait > 0) begin
            chk("wait_req_low", 32'(req), 32'd0);
            chk("wait_stall", 32'(stall), 32'd1);
            for (int i = 1; i < rsp_wait; i++) begin
                step();
                chk("wait_stall_hold", 32'(stall), 32'd1);
                chk("wait_no_lvalid", 32'(load_valid), 32'd0);
            end
            rvalid = 1'b1;
            rdata  = v.rdata;
            step();
            rvalid = 1'b0;
        end
        rdata = 32'h0;
        chk("done_lvalid", 32'(load_valid), v.exp_we ? 32'd0 : 32'd1);
        if (!v.exp_we) chk("done_ldata", load_data, v.exp_ldata);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_ready", 32'(op_ready), 32'd1);
        chk("done_req", 32'(req), 32'd0);
        step();
        chk("post_lvalid", 32'(load_valid), 32'd0);
    endtask

    vec_t vecs [11];
    vec_t hv;
    int   req_cycles;
    logic seen;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op   addr        sdata        rdata        exp_addr     exp_wdata    wstrb    we    ldata
        vecs[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80FF0000, 32'h100, 32'h0,        4'b0000, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80FF0000, 32'h100, 32'h0,        4'b0000, 1'b0, 32'h00000080};
        vecs[3]  = '{LHU, 32'h102, 32'h0,        32'h80FF0000, 32'h100, 32'h0,        4'b0000, 1'b0, 32'h000080FF};
        vecs[4]  = '{LH,  32'h102, 32'h0,        32'h80FF0000, 32'h100, 32'h0,        4'b0000, 1'b0, 32'hFFFF80FF};
        vecs[5]  = '{LB,  32'h101, 32'h0,        32'h12345678, 32'h100, 32'h0,        4'b0000, 1'b0, 32'h00000056};
        vecs[6]  = '{LH,  32'h200, 32'h0,        32'h1234F00D, 32'h200, 32'h0,        4'b0000, 1'b0, 32'hFFFFF00D};
        vecs[7]  = '{SB,  32'h101, 32'h000000AB, 32'h0,        32'h100, 32'hABABABAB, 4'b0010, 1'b1, 32'h0};
        vecs[8]  = '{SH,  32'h10A, 32'h0000BEEF, 32'h0,        32'h108, 32'hBEEFBEEF, 4'b1100, 1'b1, 32'h0};
        vecs[9]  = '{SW,  32'h10C, 32'hCAFEF00D, 32'h0,        32'h10C, 32'hCAFEF00D, 4'b1111, 1'b1, 32'h0};
        vecs[10] = '{SB,  32'h203, 32'h11223344, 32'h0,        32'h200, 32'h44444444, 4'b1000, 1'b1, 32'h0};

        rst = 1'b1; op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; sdata = 32'h0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        step();
        step();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ldata", load_data, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) run_op(vecs[i], 0, 1);

        // Non-memory codes are dropped without stalling or touching the bus
        op_valid = 1'b1; mem_op = 4'b0000; addr = 32'h700;
        #1;
        chk("nop_stall", 32'(stall), 32'd0);
        step();
        mem_op = 4'b0101;
        #1;
        chk("nop2_stall", 32'(stall), 32'd0);
        step();
        op_valid = 1'b0; mem_op = 4'h0;
        chk("nop_req", 32'(req), 32'd0);
        chk("nop_ready", 32'(op_ready), 32'd1);

        // Grant withheld 5 cycles, then normal response
        hv = '{LW, 32'h300, 32'h0, 32'h0BADF00D, 32'h300, 32'h0, 4'b0000, 1'b0, 32'h0BADF00D};
        run_op(hv, 5, 1);
        // Grant and response in the same cycle
        hv = '{LBU, 32'h301, 32'h0, 32'h0000AA00, 32'h300, 32'h0, 4'b0000, 1'b0, 32'h000000AA};
        run_op(hv, 0, 0);
        // Store ack delayed 3 cycles after grant
        hv = '{SH, 32'h302, 32'h00001234, 32'h0, 32'h300, 32'h12341234, 4'b1100, 1'b1, 32'h0};
        run_op(hv, 0, 3);

        // Timeout: no grant ever
        op_valid = 1'b1; mem_op = LW; addr = 32'h400;
        step();
        op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0;
        req_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus_err) seen = 1'b1;
            else begin
                if (req) req_cycles++;
                step();
            end
        end
        chk("tmo_seen", 32'(seen), 32'd1);
        chk("tmo_req_cycles", 32'(req_cycles), 32'd255);
        chk("tmo_req_drop", 32'(req), 32'd0);
        chk("tmo_ready", 32'(op_ready), 32'd1);
        chk("tmo_lvalid", 32'(load_valid), 32'd0);
        rvalid = 1'b1; rdata = 32'h55555555;
        step();
        rvalid = 1'b0; rdata = 32'h0;
        chk("tmo_pulse_once", 32'(bus_err), 32'd0);
        chk("late_rvalid_ignored", 32'(load_valid), 32'd0);
        chk("tmo_stall", 32'(stall), 32'd0);

        // Reset during REQ of a store clears the bus side
        op_valid = 1'b1; mem_op = SW; addr = 32'h604; sdata = 32'h5A5A5A5A;
        step();
        op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; sdata = 32'h0;
        chk("rreq_req", 32'(req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rreq_req", 32'(req), 32'd0);
        chk("rreq_we", 32'(we), 32'd0);
        chk("rreq_wstrb", 32'(wstrb), 32'd0);
        chk("rreq_wdata", wdata, 32'h0);
        chk("rreq_addr", maddr, 32'h0);

        // Reset during WAIT_RSP of a load, then a late response
        op_valid = 1'b1; mem_op = LW; addr = 32'h500;
        step();
        op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("rwait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFFFFFF;
        step();
        rvalid = 1'b0; rdata = 32'h0;
        chk("rwait_lvalid", 32'(load_valid), 32'd0);
        chk("rwait_ldata", load_data, 32'h0);
        chk("rwait_req", 32'(req), 32'd0);
        chk("rwait_addr", maddr, 32'h0);
        chk("rwait_bus_err", 32'(bus_err), 32'd0);
        chk("rwait_misaligned", 32'(misaligned), 32'd0);
        chk("rwait_ready", 32'(op_ready), 32'd1);
        chk("rwait_stall_off", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
